// File: rtl/modsub.sv
// Pipelined modular subtractor C = (A - B) mod q with per-stage valid/ready handshake.
// Up to three optional register stages (input capture, difference/correction, result); bubbles collapse.
module modsub #(
  parameter int LOGA   = 64,
  parameter int LOGB   = 64,
  parameter int LOGQ   = 64,
  parameter int LOGQH  = 47,
  parameter int FF_IN  = 1,
  parameter int FF_SUB = 1,
  parameter int FF_OUT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [LOGA-1:0] A,
  input  logic [LOGB-1:0] B,
  input  logic [LOGQ-1:0] q,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LOGQ-1:0] C
);

  localparam int W = LOGQ - LOGQH;

  logic [LOGQ-1:0] qEff;
  logic            unusedQBits;

  // Only the restricted modulus form is honoured; the low middle bits of q never reach the datapath.
  assign qEff        = {q[LOGQ-1:W], {(W-1){1'b0}}, q[0]};
  assign unusedQBits = ^q[W-1:1];

  logic            s0Valid, s0Ready;
  logic [LOGA-1:0] s0A;
  logic [LOGB-1:0] s0B;
  logic [LOGQ-1:0] s0Q;

  logic            s1Valid, s1Ready;
  logic [LOGQ-1:0] s1C;

  logic            s2Valid, s2Ready;
  logic [LOGQ-1:0] s2C;

  logic [LOGA:0]   diff;
  logic [LOGQ-1:0] diffQ;
  logic [LOGQ-1:0] subC;

  generate
    if (FF_IN != 0) begin : gInReg
      logic            valid_q, valid_d;
      logic [LOGA-1:0] a_q, a_d;
      logic [LOGB-1:0] b_q, b_d;
      logic [LOGQ-1:0] qe_q, qe_d;

      assign s0Ready = !valid_q || s1Ready;

      always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        qe_d    = qe_q;
        if (s0Ready) begin
          valid_d = in_valid;
          if (in_valid) begin
            a_d  = A;
            b_d  = B;
            qe_d = qEff;
          end
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          valid_q <= 1'b0;
          a_q     <= '0;
          b_q     <= '0;
          qe_q    <= '0;
        end else begin
          valid_q <= valid_d;
          a_q     <= a_d;
          b_q     <= b_d;
          qe_q    <= qe_d;
        end
      end

      assign s0Valid = valid_q;
      assign s0A     = a_q;
      assign s0B     = b_q;
      assign s0Q     = qe_q;
    end else begin : gInPass
      assign s0Ready = s1Ready;
      assign s0Valid = in_valid;
      assign s0A     = A;
      assign s0B     = B;
      assign s0Q     = qEff;
    end
  endgenerate

  // A borrow out of the extended difference means A < B, so a single add of q brings it back into range.
  assign diff  = {1'b0, s0A} - {1'b0, s0B};
  assign diffQ = diff[LOGQ-1:0] + s0Q;
  assign subC  = diff[LOGA] ? diffQ : diff[LOGQ-1:0];

  generate
    if (FF_SUB != 0) begin : gSubReg
      logic            valid_q, valid_d;
      logic [LOGQ-1:0] c_q, c_d;

      assign s1Ready = !valid_q || s2Ready;

      always_comb begin
        valid_d = valid_q;
        c_d     = c_q;
        if (s1Ready) begin
          valid_d = s0Valid;
          if (s0Valid) begin
            c_d = subC;
          end
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          valid_q <= 1'b0;
          c_q     <= '0;
        end else begin
          valid_q <= valid_d;
          c_q     <= c_d;
        end
      end

      assign s1Valid = valid_q;
      assign s1C     = c_q;
    end else begin : gSubPass
      assign s1Ready = s2Ready;
      assign s1Valid = s0Valid;
      assign s1C     = subC;
    end
  endgenerate

  generate
    if (FF_OUT != 0) begin : gOutReg
      logic            valid_q, valid_d;
      logic [LOGQ-1:0] c_q, c_d;

      assign s2Ready = !valid_q || out_ready;

      always_comb begin
        valid_d = valid_q;
        c_d     = c_q;
        if (s2Ready) begin
          valid_d = s1Valid;
          if (s1Valid) begin
            c_d = s1C;
          end
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          valid_q <= 1'b0;
          c_q     <= '0;
        end else begin
          valid_q <= valid_d;
          c_q     <= c_d;
        end
      end

      assign s2Valid = valid_q;
      assign s2C     = c_q;
    end else begin : gOutPass
      assign s2Ready = out_ready;
      assign s2Valid = s1Valid;
      assign s2C     = s1C;
    end
  endgenerate

  // Reset masks the handshake outputs too, so even the pass-through build is silent while held in reset.
  assign in_ready  = rst & s0Ready;
  assign out_valid = rst & s2Valid;
  assign C         = rst ? s2C : '0;

endmodule
